fft_output_serializer: RTL and testbench

Back end of the 8-point FFT datapath. It captures one 8-sample complex frame, presented in parallel by the last butterfly stage, and streams it out one sample per cycle on a valid/ready interface. It is the parallel-to-serial counterpart of the bit-reversed parallel input side. It double-buffers frames so the free-running FFT pipeline can deliver a new frame while the previous one drains. Frames that arrive with no buffer free are dropped and counted.

---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_frame_buf.sv | 28 ++
 rtl/fft_output_serializer.sv | 117 +++++++++++
 tb/tb_fft_output_serializer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame size, index bit-reversal and the complex sample type.
// The FFT stages and the output serializer both import this package.
package fft_pkg;

  localparam int N        = 8;
  localparam int LOG2N    = 3;
  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } cplx_t;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// One complex frame of N samples held in registers. A load replaces the whole
// frame in one cycle, so a PENDING to ACTIVE move is a single parallel copy.
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [N-1:0][1:0][WIDTH-1:0]  din,
  output logic [N-1:0][1:0][WIDTH-1:0]  dout
);

  logic [N-1:0][1:0][WIDTH-1:0] mem;

  // NOTE: the sample registers are reset on purpose so the streamed outputs read 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (load) begin
      mem <= din;
    end
  end

  assign dout = mem;

endmodule

// File: rtl/fft_output_serializer.sv
// Double-buffered parallel-to-serial back end of the 8-point FFT: captures a whole
// frame, streams it one sample per cycle on valid/ready, and counts dropped frames.
module fft_output_serializer
  import fft_pkg::*;
#(
  parameter int WIDTH  = SAMPLE_W,
  parameter bit BITREV = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  input  logic signed [WIDTH-1:0] x_in_0_real,
  input  logic signed [WIDTH-1:0] x_in_1_real,
  input  logic signed [WIDTH-1:0] x_in_2_real,
  input  logic signed [WIDTH-1:0] x_in_3_real,
  input  logic signed [WIDTH-1:0] x_in_4_real,
  input  logic signed [WIDTH-1:0] x_in_5_real,
  input  logic signed [WIDTH-1:0] x_in_6_real,
  input  logic signed [WIDTH-1:0] x_in_7_real,
  input  logic signed [WIDTH-1:0] x_in_0_imag,
  input  logic signed [WIDTH-1:0] x_in_1_imag,
  input  logic signed [WIDTH-1:0] x_in_2_imag,
  input  logic signed [WIDTH-1:0] x_in_3_imag,
  input  logic signed [WIDTH-1:0] x_in_4_imag,
  input  logic signed [WIDTH-1:0] x_in_5_imag,
  input  logic signed [WIDTH-1:0] x_in_6_imag,
  input  logic signed [WIDTH-1:0] x_in_7_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_real,
  output logic signed [WIDTH-1:0] out_imag,
  output logic [LOG2N-1:0]        out_index,
  output logic                    out_last,
  output logic [7:0]              drop_count
);

  typedef logic [N-1:0][1:0][WIDTH-1:0] frame_t;

  frame_t            in_frame, act_frame, pend_frame, act_din;
  logic              act_full, pend_full;
  logic [LOG2N-1:0]  pos;
  logic              xfer, done, accept;
  logic              load_act_in, load_act_pend, load_pend, act_load;

  assign in_frame[0] = {x_in_0_real, x_in_0_imag};
  assign in_frame[1] = {x_in_1_real, x_in_1_imag};
  assign in_frame[2] = {x_in_2_real, x_in_2_imag};
  assign in_frame[3] = {x_in_3_real, x_in_3_imag};
  assign in_frame[4] = {x_in_4_real, x_in_4_imag};
  assign in_frame[5] = {x_in_5_real, x_in_5_imag};
  assign in_frame[6] = {x_in_6_real, x_in_6_imag};
  assign in_frame[7] = {x_in_7_real, x_in_7_imag};

  // An accept implies PENDING is empty, so the two ACTIVE load sources never collide.
  assign xfer          = act_full && out_ready;
  assign done          = xfer && (pos == LOG2N'(N - 1));
  assign accept        = frame_valid && !pend_full;
  assign load_act_in   = accept && (!act_full || done);
  assign load_act_pend = done && pend_full;
  assign load_pend     = accept && act_full && !done;
  assign act_load      = load_act_in || load_act_pend;
  assign act_din       = load_act_pend ? pend_frame : in_frame;

  fft_frame_buf #(.WIDTH(WIDTH)) u_active (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (act_load),
    .din   (act_din),
    .dout  (act_frame)
  );

  fft_frame_buf #(.WIDTH(WIDTH)) u_pending (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_pend),
    .din   (in_frame),
    .dout  (pend_frame)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_full   <= 1'b0;
      pend_full  <= 1'b0;
      pos        <= '0;
      drop_count <= '0;
    end else begin
      if (act_load) begin
        act_full <= 1'b1;
        pos      <= '0;
      end else if (done) begin
        act_full <= 1'b0;
        pos      <= '0;
      end else if (xfer) begin
        pos <= pos + 1'b1;
      end

      if (load_pend) begin
        pend_full <= 1'b1;
      end else if (load_act_pend) begin
        pend_full <= 1'b0;
      end

      if (frame_valid && pend_full && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  assign frame_ready = !pend_full;
  assign out_valid   = act_full;
  assign out_index   = BITREV ? bitrev3(pos) : pos;
  assign out_real    = act_frame[out_index][1];
  assign out_imag    = act_frame[out_index][0];
  assign out_last    = (pos == LOG2N'(N - 1));

endmodule

// File: tb/tb_fft_output_serializer.sv
// Randomized bench for fft_output_serializer against a queue-based model of the
// sample stream; a second instance with BITREV=1 covers the reordered index path.
module tb_fft_output_serializer;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic [2:0]         idx;
  } samp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [15:0] fr_re [8];
  logic signed [15:0] fr_im [8];

  logic               frame_ready, out_valid, out_last;
  logic signed [15:0] out_real, out_imag;
  logic [2:0]         out_index;
  logic [7:0]         drop_count;

  logic               b_frame_ready, b_out_valid, b_out_last;
  logic signed [15:0] b_out_real, b_out_imag;
  logic [2:0]         b_out_index;
  logic [7:0]         b_drop_count;

  samp_t exp_q[$];
  int    m_drop;
  int    n_checks = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  fft_output_serializer #(.WIDTH(16), .BITREV(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .x_in_0_real(fr_re[0]), .x_in_1_real(fr_re[1]), .x_in_2_real(fr_re[2]), .x_in_3_real(fr_re[3]),
    .x_in_4_real(fr_re[4]), .x_in_5_real(fr_re[5]), .x_in_6_real(fr_re[6]), .x_in_7_real(fr_re[7]),
    .x_in_0_imag(fr_im[0]), .x_in_1_imag(fr_im[1]), .x_in_2_imag(fr_im[2]), .x_in_3_imag(fr_im[3]),
    .x_in_4_imag(fr_im[4]), .x_in_5_imag(fr_im[5]), .x_in_6_imag(fr_im[6]), .x_in_7_imag(fr_im[7]),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_index(out_index), .out_last(out_last), .drop_count(drop_count)
  );

  fft_output_serializer #(.WIDTH(16), .BITREV(1'b1)) dut_br (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ready(b_frame_ready),
    .x_in_0_real(fr_re[0]), .x_in_1_real(fr_re[1]), .x_in_2_real(fr_re[2]), .x_in_3_real(fr_re[3]),
    .x_in_4_real(fr_re[4]), .x_in_5_real(fr_re[5]), .x_in_6_real(fr_re[6]), .x_in_7_real(fr_re[7]),
    .x_in_0_imag(fr_im[0]), .x_in_1_imag(fr_im[1]), .x_in_2_imag(fr_im[2]), .x_in_3_imag(fr_im[3]),
    .x_in_4_imag(fr_im[4]), .x_in_5_imag(fr_im[5]), .x_in_6_imag(fr_im[6]), .x_in_7_imag(fr_im[7]),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_real(b_out_real), .out_imag(b_out_imag),
    .out_index(b_out_index), .out_last(b_out_last), .drop_count(b_drop_count)
  );

  // Model: the queue holds every sample still owed downstream, in delivery order.
  // Frames held = ceil(queued/8); a new frame fits while fewer than two are held.
  task automatic model_edge();
    int held;
    held = (exp_q.size() + 7) / 8;
    if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
    if (frame_valid) begin
      if (held < 2) begin
        for (int k = 0; k < 8; k++) exp_q.push_back('{re: fr_re[k], im: fr_im[k], idx: 3'(k)});
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
  endtask

  function automatic logic [45:0] model_vec();
    logic rdy;
    rdy = ((exp_q.size() + 7) / 8) < 2;
    if (exp_q.size() > 0)
      return {1'b1, rdy, 8'(m_drop), exp_q[0].re, exp_q[0].im, exp_q[0].idx, exp_q[0].idx == 3'd7};
    return {1'b0, rdy, 8'(m_drop), 36'd0};
  endfunction

  function automatic logic [45:0] obs_vec();
    return {out_valid, frame_ready, drop_count,
            out_valid ? {out_real, out_imag, out_index, out_last} : 36'd0};
  endfunction

  task automatic new_frame();
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = 16'($urandom);
      fr_im[k] = 16'($urandom);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    frame_valid = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    m_drop = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL reset_frame_ready got %b need 1", frame_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b need 0", out_valid); end
    n_checks++; if (out_real !== 16'sd0 || out_imag !== 16'sd0) begin n_fail++; $display("FAIL reset_data got %h/%h need 0/0", out_real, out_imag); end
    n_checks++; if (out_index !== 3'd0 || out_last !== 1'b0) begin n_fail++; $display("FAIL reset_index_last got %0d/%b need 0/0", out_index, out_last); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0d need 0", drop_count); end
  endtask

  task automatic test_single_frame();
    int br_order [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int br_n = 0;
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = 16'(k + 1);
      fr_im[k] = -16'(k + 1);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== model_vec()) begin
        n_fail++; $display("FAIL single c=%0d got %h need %h", c, obs_vec(), model_vec());
      end
      if (b_out_valid && br_n < 8) begin
        n_checks++;
        if (b_out_index !== 3'(br_order[br_n]) || b_out_real !== 16'(br_order[br_n] + 1) ||
            b_out_imag !== -16'(br_order[br_n] + 1) || b_out_last !== (br_n == 7)) begin
          n_fail++; $display("FAIL bitrev n=%0d got idx %0d re %0d last %b need idx %0d re %0d",
                             br_n, b_out_index, b_out_real, b_out_last, br_order[br_n], br_order[br_n] + 1);
        end
        br_n++;
      end
      frame_valid = (c == 0);
      @(posedge clk); model_edge();
    end
    n_checks++; if (br_n !== 8) begin n_fail++; $display("FAIL bitrev_count got %0d need 8", br_n); end
  endtask

  task automatic test_back_to_back();
    int valid_cycles = 0;
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== model_vec()) begin
        n_fail++; $display("FAIL b2b c=%0d got %h need %h", c, obs_vec(), model_vec());
      end
      if (c == 2) begin
        n_checks++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_c2 got %b need 0", frame_ready); end
      end
      if (out_valid) valid_cycles++;
      frame_valid = (c < 3);
      if (c < 3) new_frame();
      @(posedge clk); model_edge();
    end
    n_checks++; if (valid_cycles !== 16) begin n_fail++; $display("FAIL b2b_samples got %0d need 16", valid_cycles); end
    n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL b2b_drop got %0d need 1", drop_count); end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== model_vec()) begin
        n_fail++; $display("FAIL stall c=%0d got %h need %h", c, obs_vec(), model_vec());
      end
      frame_valid = (c < 160) && (c % 8 == 0);
      if (frame_valid) new_frame();
      out_ready = (c < 160) ? 1'($urandom) : 1'b1;
      @(posedge clk); model_edge();
    end
    n_checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL stall_drained got valid %b queued %0d need 0/0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int c = 0; c < 330; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== model_vec()) begin
        n_fail++; $display("FAIL sat c=%0d got %h need %h", c, obs_vec(), model_vec());
      end
      frame_valid = (c < 300);
      new_frame();
      out_ready = (c >= 300);
      @(posedge clk); model_edge();
    end
    n_checks++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_drop got %0d need 255", drop_count); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== model_vec()) begin
        n_fail++; $display("FAIL midrst_pre c=%0d got %h need %h", c, obs_vec(), model_vec());
      end
      frame_valid = (c < 2);
      new_frame();
      @(posedge clk); model_edge();
    end
    @(negedge clk);
    n_checks++; if (out_index !== 3'd3 || frame_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_setup got idx %0d ready %b need 3/0", out_index, frame_ready);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || frame_ready !== 1'b1 || out_real !== 16'sd0 || out_imag !== 16'sd0 ||
        out_index !== 3'd0 || out_last !== 1'b0 || drop_count !== 8'd0) begin
      n_fail++; $display("FAIL midrst_async got v%b r%b %h/%h i%0d l%b d%0d need all reset values",
                         out_valid, frame_ready, out_real, out_imag, out_index, out_last, drop_count);
    end
    exp_q.delete();
    m_drop = 0;
    frame_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== model_vec()) begin
        n_fail++; $display("FAIL midrst_post c=%0d got %h need %h", c, obs_vec(), model_vec());
      end
      frame_valid = (c == 0);
      if (c == 0) new_frame();
      @(posedge clk); model_edge();
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = '0;
      fr_im[k] = '0;
    end
    m_drop = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
